// File: rtl/uart_rx_deframer_if.sv
// Parallel-side and serial-line signals of the UART receive deframer.
// The master drives the line and frame configuration; the slave returns the word and status pulses.
interface uart_rx_deframer_if #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_W-1:0]     P_DATA;
    logic                  DATA_VLD;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VLD, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// Oversampling UART receiver: start detect, LSB-first deserialise, optional parity, stop check.
// Each bit is the majority of three samples around mid-bit, decided at the last edge of the bit.
module uart_rx_deframer #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                CLK,
    input  logic                RST,
    uart_rx_deframer_if.slave   bus
);
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [PRESCALE_W-1:0] r_ps;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [2:0]            r_smp;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_flag;
    logic                  r_need_high;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     r_p_data;
    logic                  r_data_vld;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic [PRESCALE_W-1:0] w_ps_in;
    logic [PRESCALE_W-1:0] w_half;
    logic [PRESCALE_W-1:0] w_smp_lo;
    logic [PRESCALE_W-1:0] w_smp_hi;
    logic [2:0]            w_smp;
    logic                  w_vote;
    logic                  w_bit_end;
    logic                  w_start;
    logic                  w_last_bit;
    logic                  w_par_exp;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.RX_IN;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_ps_in    = (bus.PRESCALE < PS_MIN) ? PS_MIN : bus.PRESCALE;
    assign w_half     = r_ps >> 1;
    assign w_smp_lo   = w_half - PS_ONE;
    assign w_smp_hi   = w_half + PS_ONE;
    assign w_bit_end  = (r_edge_cnt == (r_ps - PS_ONE));
    assign w_start    = (r_state == S_IDLE) && !r_need_high && !r_rx_s;
    assign w_last_bit = (r_bit_cnt == BCW'(DATA_W - 1));
    assign w_par_exp  = r_par_typ ? ~^r_data : ^r_data;

    // With ps=4 the last sample point coincides with the bit end, so the
    // vote uses the sample being taken this cycle rather than the register.
    always_comb begin
        w_smp = r_smp;
        if (r_edge_cnt == w_smp_lo) w_smp[0] = r_rx_s;
        if (r_edge_cnt == w_half)   w_smp[1] = r_rx_s;
        if (r_edge_cnt == w_smp_hi) w_smp[2] = r_rx_s;
    end

    assign w_vote = (w_smp[0] & w_smp[1]) | (w_smp[0] & w_smp[2]) | (w_smp[1] & w_smp[2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START:  if (w_bit_end) w_state_nxt = w_vote ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_end && w_last_bit) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
            S_STOP:   if (w_bit_end) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ps        <= '0;
            r_edge_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_smp       <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_par_flag  <= 1'b0;
            r_need_high <= 1'b0;
            r_data      <= '0;
            r_p_data    <= '0;
            r_data_vld  <= 1'b0;
            r_par_err   <= 1'b0;
            r_stp_err   <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            r_smp      <= w_smp;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                if (r_rx_s) r_need_high <= 1'b0;
                // The detecting cycle is edge 0 of the start bit.
                if (w_start) begin
                    r_edge_cnt <= PS_ONE;
                    r_ps       <= w_ps_in;
                    r_par_en   <= bus.PAR_EN;
                    r_par_typ  <= bus.PAR_TYP;
                    r_par_flag <= 1'b0;
                end else begin
                    r_edge_cnt <= '0;
                end
            end else begin
                r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + PS_ONE;
                if (w_bit_end) begin
                    case (r_state)
                        S_DATA: begin
                            r_data[r_bit_cnt] <= w_vote;
                            r_bit_cnt         <= r_bit_cnt + BCW'(1);
                        end
                        S_PARITY: if (w_vote != w_par_exp) r_par_flag <= 1'b1;
                        S_STOP: begin
                            r_stp_err   <= ~w_vote;
                            r_par_err   <= r_par_flag;
                            r_need_high <= ~w_vote;
                            if (w_vote && !r_par_flag) begin
                                r_data_vld <= 1'b1;
                                r_p_data   <= r_data;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.P_DATA   = r_p_data;
    assign bus.DATA_VLD = r_data_vld;
    assign bus.PAR_ERR  = r_par_err;
    assign bus.STP_ERR  = r_stp_err;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scenario bench for uart_rx_deframer: frames are driven bit by bit and the expected
// pulse (kind, P_DATA, arrival cycle) is queued, then matched by the output monitor.
module tb_uart_rx_deframer;
    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    logic [7:0] last_good;

    typedef struct {
        logic       vld;
        logic       par;
        logic       stp;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    uart_rx_deframer_if #(.DATA_W(8), .PRESCALE_W(6)) bus ();

    uart_rx_deframer #(.DATA_W(8), .PRESCALE_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, pending=%0d required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (bus.DATA_VLD === 1'b1 || bus.PAR_ERR === 1'b1 || bus.STP_ERR === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: vld=%b par=%b stp=%b p_data=%h at cyc %0d, required no pulse",
                         bus.DATA_VLD, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({bus.DATA_VLD, bus.PAR_ERR, bus.STP_ERR} !== {mon_e.vld, mon_e.par, mon_e.stp}) begin
                    errors++;
                    $display("FAIL pulse_kind: vld/par/stp=%b%b%b required %b%b%b",
                             bus.DATA_VLD, bus.PAR_ERR, bus.STP_ERR, mon_e.vld, mon_e.par, mon_e.stp);
                end
                checks++;
                if (bus.P_DATA !== mon_e.data) begin
                    errors++;
                    $display("FAIL p_data: got %h required %h", bus.P_DATA, mon_e.data);
                end
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL pulse_cycle: got %0d required %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the last bit cycle.
    task automatic send_frame(input logic [7:0] d, input int prog_ps, input logic pen,
                              input logic ptyp, input bit bad_par, input logic stopb,
                              input int glitch_at, input bit flip);
        int         eps;
        int         nbits;
        int         idx;
        logic       pbit;
        logic [10:0] fr;
        ev_t        e;
        eps   = (prog_ps < 4) ? 4 : prog_ps;
        nbits = pen ? 11 : 10;
        pbit  = (ptyp ? ~^d : ^d) ^ bad_par;
        fr    = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (pen) begin
            fr[9]  = pbit;
            fr[10] = stopb;
        end else begin
            fr[9]  = stopb;
        end
        e.stp = !stopb;
        e.par = pen && bad_par;
        e.vld = !e.stp && !e.par;
        if (e.vld) last_good = d;
        e.data = last_good;
        e.cyc  = cyc + 2 + nbits * eps;
        exp_q.push_back(e);
        bus.PRESCALE = 6'(prog_ps);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < eps; j++) begin
                idx = b * eps + j;
                bus.RX_IN = fr[b] ^ (idx == glitch_at);
                if (flip && idx == eps) begin
                    bus.PAR_EN   = ~pen;
                    bus.PAR_TYP  = ~ptyp;
                    bus.PRESCALE = 6'd5;
                end
                @(negedge clk);
            end
        end
        bus.PRESCALE = 6'(prog_ps);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h required 00", bus.P_DATA); end
        checks++;
        if (bus.DATA_VLD !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", bus.DATA_VLD); end
        checks++;
        if (bus.PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_par: got %b required 0", bus.PAR_ERR); end
        checks++;
        if (bus.STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_stp: got %b required 0", bus.STP_ERR); end
        rst = 1'b0;
        idle(10);
    endtask

    task automatic test_good_parity();
        idle(20);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("good_parity");
    endtask

    task automatic test_parity_error();
        idle(20);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        wait_drain("parity_error");
        checks++;
        if (bus.P_DATA !== 8'hA5) begin errors++; $display("FAIL parity_hold: got %h required a5", bus.P_DATA); end
    endtask

    task automatic test_start_glitch();
        idle(20);
        bus.PRESCALE = 6'd8;
        bus.RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        checks++;
        if (bus.P_DATA !== 8'hA5) begin errors++; $display("FAIL glitch_hold: got %h required a5", bus.P_DATA); end
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("glitch_follow");
    endtask

    task automatic test_break();
        idle(20);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        bus.RX_IN = 1'b0;
        repeat (40) @(negedge clk);
        wait_drain("break");
        checks++;
        if (bus.P_DATA !== 8'h5A) begin errors++; $display("FAIL break_hold: got %h required 5a", bus.P_DATA); end
        idle(10);
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("break_recover");
    endtask

    task automatic test_majority_back_to_back();
        idle(20);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 16 + 8, 1'b0);
        send_frame(8'h01, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("back_to_back");
    endtask

    task automatic test_prescale_and_hold();
        idle(20);
        send_frame(8'h81, 2, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("prescale_min");
        idle(20);
        send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1);
        wait_drain("config_hold");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'hE7;
        idle(20);
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            bus.RX_IN = d[b];
            repeat (8) @(negedge clk);
        end
        bus.RX_IN = d[4];
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.P_DATA, bus.DATA_VLD, bus.PAR_ERR, bus.STP_ERR} !== 11'h000) begin
            errors++;
            $display("FAIL midframe_reset_outputs: p_data=%h vld=%b par=%b stp=%b required all 0",
                     bus.P_DATA, bus.DATA_VLD, bus.PAR_ERR, bus.STP_ERR);
        end
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        idle(40);
        checks++;
        if (bus.P_DATA !== 8'h00) begin errors++; $display("FAIL midframe_no_frame: got %h required 00", bus.P_DATA); end
        send_frame(8'h6E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        wait_drain("after_reset");
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        cyc          = 0;
        last_good    = 8'h00;
        rst          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        @(negedge clk);
        test_reset();
        test_good_parity();
        test_parity_error();
        test_start_glitch();
        test_break();
        test_majority_back_to_back();
        test_prescale_and_hold();
        test_reset_midframe();
        idle(50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side UART block. Oversamples the serial line, detects the start bit and deserializes DATA_W bits LSB first. It checks an optional even/odd parity bit and the stop bit, then presents the received word with a one-cycle valid pulse. It mirrors the transmit path (serializer plus parity calculator) and uses the same PAR_EN/PAR_TYP encoding: 0 = even, 1 = odd.

Parameters:
DATA_W, 8, data bits per frame
PRESCALE_W, 6, width of the oversampling-ratio input

Ports:
CLK  in  1  receiver clock (oversampling clock)
RST  in  1  asynchronous reset, active-high
RX_IN  in  1  serial line, idle high, asynchronous to CLK
PRESCALE  in  PRESCALE_W  CLK cycles per bit; values <4 behave as 4
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
P_DATA  out  DATA_W  last correctly received word
DATA_VLD  out  1  one-cycle pulse, P_DATA updated
PAR_ERR  out  1  one-cycle pulse, parity mismatch
STP_ERR  out  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset: clock is CLK; reset is asynchronous, active-high on RST. RST=1 forces state IDLE, the counters to 0, P_DATA=0, DATA_VLD=0, PAR_ERR=0 and STP_ERR=0. Reset mid-frame aborts the frame with no pulse.
- RX_IN passes through a 2-flop synchronizer (reset value 1). rx_s is the synchronized value. All timing below refers to rx_s.
- PRESCALE, PAR_EN and PAR_TYP are captured on the IDLE->START transition and held for the whole frame. Changes mid-frame have no effect until the next frame.
- edge_cnt counts 0..ps-1 within each bit (ps = captured prescale). bit_cnt counts data bits 0..DATA_W-1.
- Sampling: rx_s is captured at edge_cnt = ps/2-1, ps/2 and ps/2+1 (integer divide). The bit value is the majority of the three samples. It is evaluated at edge_cnt = ps-1.
- States:
  - IDLE: wait for rx_s=0. The first cycle with rx_s=0 counts as edge_cnt=0 of START.
  - START: at the end of the bit, vote=0 -> DATA. vote=1 is a glitch -> IDLE, with no output pulse.
  - DATA: at each bit end, shift the vote into bit position bit_cnt. After bit DATA_W-1, go to PARITY if PAR_EN else STOP.
  - PARITY: expected bit = ^data (even) or ~^data (odd). A mismatch sets an internal error flag. Go to STOP.
  - STOP: at the end of the bit, evaluate the outputs and go to IDLE.
- Outputs are registered and asserted in the cycle after STOP's edge_cnt=ps-1:
  - stop vote 0 -> STP_ERR=1;
  - parity flag -> PAR_ERR=1;
  - both can pulse together;
  - DATA_VLD=1 and P_DATA<=data only if neither error occurred.
- P_DATA holds its value until the next good frame. All pulses are exactly one cycle.
- Back-to-back: a start bit immediately after the stop bit is accepted, because IDLE samples rx_s=0 in the cycle after STOP ends.
- Frame length = (1 + DATA_W + PAR_EN + 1) * ps cycles from the first low rx_s. Input latency adds 2 cycles for the synchronizer.
- A break (line held low) gives STP_ERR. It re-enters START only after rx_s returns high and then falls again; rx_s low in IDLE right after a STP_ERR frame is ignored until a high is seen.

Test Plan:
- Good frame, parity: PRESCALE=8, PAR_EN=1, PAR_TYP=0. Send 0xA5 with LSB-first bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Expect DATA_VLD for 1 cycle, P_DATA=0xA5, no errors, pulse 88 cycles after the first low rx_s.
- Parity error: PAR_TYP=1, send 0x3C with parity bit 0 (expected 1). Expect PAR_ERR pulse, DATA_VLD=0, P_DATA unchanged (0xA5).
- Start glitch: PRESCALE=8, RX_IN low for 2 cycles then high. Expect no pulses and return to IDLE. A following valid frame 0x5A is received correctly.
- Stop error and break: send 0x00 with stop=0 and hold low for 40 cycles. Expect a single STP_ERR, no DATA_VLD, and no new frame until the line goes high then low.
- Majority vote and back-to-back: PRESCALE=16, PAR_EN=0. Send frames 0xFF then 0x01 with no idle gap. Inject a 1-cycle inverted glitch at edge_cnt=8 of data bit 3 of the first frame. Expect two DATA_VLD pulses 160 cycles apart, with P_DATA=0xFF then 0x01.
- Reset mid-frame: assert RST during bit 4 of a frame. Expect all outputs 0 immediately, and no pulse for the aborted frame. The next full frame after release is received correctly.
